// File: rtl/mesh_port_scheduler.sv
// Wormhole output-port scheduler: round-robin pick in IDLE,
// then the link stays locked to one input until its tail flit leaves.
module mesh_port_scheduler #(
  parameter int NUM_REQ = 5,
  parameter int WIDTH   = 32,
  parameter int IDX_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]       in_tail,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_tail,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] rr_q;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             act;
  logic             xfer;
  logic             owner_last;
  logic [IDX_W-1:0] rr_next;

  // Scan from the highest offset down so the lowest offset wins.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    idx      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ))
        sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (in_valid[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  // The reset cycle itself must never move a flit.
  assign act        = (state_q == LOCKED) && !rst;
  assign xfer       = act && in_valid[owner_q] && out_ready;
  assign owner_last = (owner_q == IDX_W'(NUM_REQ - 1));
  assign rr_next    = owner_last ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            owner_q <= pick_idx;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && in_tail[owner_q]) begin
            state_q <= IDLE;
            rr_q    <= rr_next;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_tail  = 1'b0;
    if (act) begin
      in_ready[owner_q] = out_ready;
      out_valid = in_valid[owner_q];
      out_data  = in_data[owner_q*WIDTH +: WIDTH];
      out_tail  = in_tail[owner_q];
    end
  end

  assign busy     = (state_q == LOCKED);
  assign grant_id = busy ? owner_q : '0;

endmodule

// File: doc/mesh_port_scheduler.md
Name: mesh_port_scheduler

Overview:
- Clocked wormhole output-port scheduler for a mesh router.
- Shares one output link between NUM_REQ input ports (N, E, S, W, PE by default) using round-robin priority.
- Once a head flit wins, the grant is locked to that input until its tail flit transfers, so packets are never interleaved.
- Sequences the shared merge datapath by presenting the current winner's flits on a single valid/ready output.

Parameters:
NUM_REQ, 5, number of requesting input ports (2..8)
WIDTH, 32, flit data width in bits
IDX_W, 3, width of grant index; must satisfy 2**IDX_W >= NUM_REQ

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  NUM_REQ  per-port flit valid
in_data  input  NUM_REQ*WIDTH  per-port flit data; port i occupies bits [i*WIDTH +: WIDTH]
in_tail  input  NUM_REQ  per-port flag marking the last flit of a packet
in_ready  output  NUM_REQ  per-port flit accepted this cycle
out_valid  output  1  output flit valid
out_data  output  WIDTH  output flit data
out_tail  output  1  output flit is the tail
out_ready  input  1  downstream accepts flit
grant_id  output  IDX_W  index of the locked owner; 0 when idle
busy  output  1  high while in LOCKED

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=IDLE, owner=0, rr_ptr=0, grant_id=0, busy=0, out_valid=0, out_tail=0, out_data=0, in_ready=all 0.
- A reset asserted mid-packet abandons the packet immediately. No flit transfers on the reset cycle.
- FSM, two states:
  - IDLE: if any in_valid is high, select the first asserted index searching rr_ptr, rr_ptr+1, ..., wrapping NUM_REQ-1 to 0. Register it as owner and go to LOCKED. Otherwise stay in IDLE.
  - LOCKED: busy=1, grant_id=owner.
- Grant latency: exactly 1 cycle from in_valid sampled in IDLE to the first possible transfer. No flit moves in IDLE; in_ready=0 there.
- Datapath in LOCKED is combinational from the owner:
  - out_valid = in_valid[owner]
  - out_data = in_data[owner]
  - out_tail = in_tail[owner]
  - in_ready[owner] = out_ready; all other in_ready = 0
- Transfer occurs when out_valid && out_ready.
- Transfer with out_tail=1: next state IDLE, rr_ptr = owner+1 mod NUM_REQ.
- Transfer with out_tail=0: stay LOCKED.
- Owner dropping in_valid mid-packet (bubble): the lock is held. out_valid=0, and no other port may transfer.
- Downstream backpressure (out_ready=0): the lock is held. Data is not sampled, so the upstream must hold its flit stable.
- Single-flit packet (head=tail): 1 IDLE cycle plus 1 LOCKED transfer cycle.
- A port requesting back-to-back packets loses priority to any other valid port after its tail. If it is the only requester, it regrants after a 1-cycle IDLE bubble.
- Requests arriving while LOCKED are ignored until the next IDLE.
- In IDLE with out_valid=0, out_data=0 and out_tail=0.
- Throughput: 1 flit/cycle within a packet; at most 1 bubble cycle between packets.
- Owner and rr_ptr are always < NUM_REQ. Wrap is mod NUM_REQ, not 2**IDX_W.

Test Plan:
1. rst for 2 cycles, all inputs 0 -> all outputs 0, busy=0, grant_id=0. Assert rst mid-packet -> next cycle IDLE, in_ready=0, grant_id=0.
2. Port 2 sends a 3-flit packet (0xA1, 0xA2, 0xA3 tail) with out_ready=1 -> grant_id=2 one cycle after in_valid. out_data is A1, A2, A3 on consecutive cycles. busy drops the cycle after A3. rr_ptr=3.
3. Ports 0, 1, 4 all hold 1-flit packets continuously from reset -> service order 0, 1, 4, 0, 1, 4, with one IDLE cycle between grants.
4. Port 4 owns the link, with rr_ptr wrap checked at NUM_REQ=5 -> after port 4's tail, a simultaneous request from ports 0 and 3 grants port 0.
5. Port 1 is mid-packet, out_ready=0 for 4 cycles while port 3 is valid -> out_data is held at port 1's flit and in_ready=0 everywhere. Once out_ready is released, port 1 finishes before port 3 is granted.
6. Port 0 drops in_valid for 2 cycles between its head and tail while port 2 is valid -> out_valid=0 for those cycles, grant_id stays 0, and port 2 is not granted until port 0's tail transfers.
